// File: rtl/inst_fetch_if.sv
// Fetch-unit bus: instruction-memory request/response channel, the
// decode-side instruction handshake and the execute-side redirect.
interface inst_fetch_if #(
   parameter int unsigned nbit = 32
);
   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [nbit-1:0] imem_addr;
   logic            imem_rsp_valid;
   logic [nbit-1:0] imem_rsp_data;
   logic            inst_valid;
   logic            inst_ready;
   logic [nbit-1:0] inst;
   logic [nbit-1:0] inst_pc;
   logic            PCSel;
   logic [nbit-1:0] alu_target;

   // Fetch unit side
   modport master (
      output imem_req_valid, imem_addr, inst_valid, inst, inst_pc,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
             inst_ready, PCSel, alu_target
   );

   // Memory / decode / execute side
   modport slave (
      input  imem_req_valid, imem_addr, inst_valid, inst, inst_pc,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data,
             inst_ready, PCSel, alu_target
   );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch unit: owns the PC, issues in-order word requests,
// buffers {pc, inst} pairs and flushes everything stale on a redirect.
module inst_fetch #(
   parameter int unsigned    nbit     = 32,
   parameter logic [nbit-1:0] RESET_PC = '0,
   parameter int unsigned    DEPTH    = 4
) (
   input logic        clk,
   input logic        rst_n,
   inst_fetch_if.master bus
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam logic [nbit-1:0] NOP = nbit'(32'h0000_0013);

   logic [nbit-1:0] fetch_pc_q, fetch_pc_d;
   logic [nbit-1:0] rsp_pc_q, rsp_pc_d;
   logic [CW-1:0]   out_cnt_q, out_cnt_d;
   logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [nbit-1:0] pc_mem   [DEPTH];
   logic [nbit-1:0] inst_mem [DEPTH];

   logic            head_valid;
   logic            pop;
   logic            redirect;
   logic [CW:0]     credit_sum;
   logic            req_valid;
   logic            req_fire;
   logic            rsp_ok;
   logic            push;
   logic [nbit-1:0] target;

   // Handshake decode and credit: outstanding plus buffered, net of this cycle's pop
   always_comb begin
      head_valid = (cnt_q != '0);
      pop        = head_valid && bus.inst_ready;
      redirect   = pop && bus.PCSel;
      credit_sum = {1'b0, out_cnt_q} + {1'b0, cnt_q} - {{CW{1'b0}}, pop};
      req_valid  = rst_n && (credit_sum < (CW+1)'(DEPTH));
      req_fire   = req_valid && bus.imem_req_ready;
      rsp_ok     = bus.imem_rsp_valid && (out_cnt_q != '0);
      push       = rsp_ok && (drop_cnt_q == '0) && !redirect;
      target     = bus.alu_target & ~nbit'(3);
   end

   // Next-state: normal fetch/response accounting, overridden by a redirect
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      rsp_pc_d   = rsp_pc_q;
      drop_cnt_d = drop_cnt_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      out_cnt_d  = out_cnt_q + CW'(req_fire) - CW'(rsp_ok);
      cnt_d      = cnt_q + CW'(push) - CW'(pop);
      if (req_fire) fetch_pc_d = fetch_pc_q + nbit'(4);
      if (rsp_ok && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CW'(1);
      if (push) begin
         rsp_pc_d = rsp_pc_q + nbit'(4);
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      // Every request still unanswered after this cycle (including one accepted
      // now at the old PC) is stale; a response arriving now is simply not pushed.
      if (redirect) begin
         fetch_pc_d = target;
         rsp_pc_d   = target;
         drop_cnt_d = out_cnt_d;
         cnt_d      = '0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
      end
   end

   // Control state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_q <= RESET_PC;
         rsp_pc_q   <= RESET_PC;
         out_cnt_q  <= '0;
         drop_cnt_q <= '0;
         cnt_q      <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         rsp_pc_q   <= rsp_pc_d;
         out_cnt_q  <= out_cnt_d;
         drop_cnt_q <= drop_cnt_d;
         cnt_q      <= cnt_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
      end
   end

   // Buffer storage write; contents are qualified by cnt_q so need no reset
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr_q]   <= rsp_pc_q;
         inst_mem[wr_ptr_q] <= bus.imem_rsp_data;
      end
   end

   // Outputs: registered PC and buffer head, NOP/0 when the buffer is empty
   always_comb begin
      bus.imem_req_valid = req_valid;
      bus.imem_addr      = fetch_pc_q;
      bus.inst_valid     = head_valid;
      bus.inst           = head_valid ? inst_mem[rd_ptr_q] : NOP;
      bus.inst_pc        = head_valid ? pc_mem[rd_ptr_q] : '0;
   end
endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch unit for the 32-bit RISC-V core. It owns the program counter and issues in-order word requests to instruction memory. It buffers returned words with their PCs and presents them to the decode/controller stage through a valid/ready handshake. When a taken branch or jump is reported back from execute (PCSel with the ALU target), it redirects fetch and discards all stale instructions, both buffered and in flight.

## Interface
Parameters:
- nbit, 32, datapath/address width
- RESET_PC, 32'h0000_0000, first fetch address after reset
- DEPTH, 4, instruction buffer entries; also the cap on outstanding requests plus buffered entries (power of 2, ≥2)

Ports:
- clk  in  1  core clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_addr  out  nbit  word address of request; bits [1:0] always 0
- imem_rsp_valid  in  1  response valid; one per accepted request, in order, ≥1 cycle after acceptance
- imem_rsp_data  in  nbit  instruction word
- inst_valid  out  1  buffer head valid
- inst_ready  in  1  decode consumes head
- inst  out  nbit  head instruction; 32'h0000_0013 (NOP) when inst_valid=0
- inst_pc  out  nbit  PC of head; 0 when inst_valid=0
- PCSel  in  1  redirect request; sampled only in a cycle where inst_valid && inst_ready
- alu_target  in  nbit  redirect address; bits [1:0] forced to 0 internally

## Operation
State:
- fetch_pc: next request address
- rsp_pc: PC tagged on the next kept response
- out_cnt: accepted requests without a response, 0..DEPTH
- drop_cnt: responses still to discard, 0..DEPTH
- FIFO of {pc, inst}, count 0..DEPTH

Fetch and buffering:
- Credit: imem_req_valid = (out_cnt + count − pop) < DEPTH, where pop = inst_valid && inst_ready. The signal does not depend on imem_req_ready.
- imem_addr = fetch_pc. On a request handshake, fetch_pc += 4 (mod 2^nbit; 0xFFFF_FFFC wraps to 0) and out_cnt++.
- On a response, out_cnt−−.
  - If drop_cnt > 0: discard the word and decrement drop_cnt.
  - Otherwise: push {rsp_pc, imem_rsp_data} and rsp_pc += 4.
- Overflow cannot occur by construction. A response with out_cnt = 0 is a protocol error: ignore it (assertion in the bench).
- Head pops on pop.

Redirect (pop && PCSel):
- fetch_pc and rsp_pc ← {alu_target[nbit-1:2], 2'b00}.
- The FIFO is flushed, including any response pushed that cycle.
- drop_cnt ← out_cnt after this cycle's request and response accounting. This counts every accepted request whose response has not yet arrived.
- A response arriving in the redirect cycle is discarded. It is not counted in drop_cnt.
- A request accepted in the redirect cycle used the old fetch_pc, so it is counted in drop_cnt.
- The first request to the target issues the following cycle if credit allows.

Simultaneous events:
- Push and pop in the same cycle: count unchanged.
- PCSel=1 without pop is ignored.

## Timing
- Reset (async assert): fetch_pc = rsp_pc = RESET_PC; out_cnt = drop_cnt = count = 0; imem_req_valid = 0 while rst_n is low; inst_valid = 0, inst = NOP, inst_pc = 0.
- First cycle after rst_n deasserts: imem_req_valid = 1, imem_addr = RESET_PC.
- Latency: a request accepted at cycle N with its response at N+L gives inst_valid at N+L+1.
- Throughput: with L = 1 and inst_ready held high, one instruction per cycle once filled, for DEPTH ≥ 2.
- Redirect penalty: redirect pop at cycle R → request to target at R+1 → first target inst_valid at R+1+L+1.
- inst_valid is low from R+1 until then. Outputs come from registers and the FIFO head only.
- Reset asserted mid-operation: everything returns to reset values immediately. Responses to pre-reset requests are the memory model's responsibility (bench resets memory too).

## Test plan
- Reset/stream: RESET_PC = 0x100, L = 1, inst_ready = 1 → addresses 0x100, 0x104, 0x108… on consecutive cycles; inst_pc = 0x100 at cycle 3 after reset release, then +4 every cycle; inst matches memory.
- Backpressure: inst_ready = 0 for 10 cycles → exactly DEPTH requests total in flight or buffered; imem_req_valid low; no loss or reorder on release.
- Redirect with in-flight: L = 3; pop with PCSel = 1 and alu_target = 0x203 while 3 requests are outstanding → those 3 responses discarded; next request address 0x200; first delivered inst_pc = 0x200.
- Redirect coinciding with response and request: response arrives and request is accepted in the redirect cycle → the response is dropped, the accepted request is dropped later, and no stale PC ever appears on inst_pc.
- Wrap: RESET_PC = 0xFFFF_FFF8 → fetch sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- Reset mid-stream: rst_n pulsed low for 1 cycle while the FIFO is full → inst_valid drops immediately; fetch restarts at RESET_PC.
